spi_arbiter: RTL and testbench
==============================

// Module: spi_arbiter
// PURPOSE
//  Round-robin arbiter for the 8 SPI requesters (DDS, synth, attenuators, ...) sharing the SPI data fifo and SPI queue fifo.
//  Sits directly upstream of spi_mux: drives its mux_select_i/enable_i so exactly one requester owns both fifos at a time.
//  Ownership lasts from grant until the requester's write completes and the top-level SPI processor reports idle.
//  Stuck owners are released by a watchdog.
// PARAMETERS
//  NUM_REQ       8     number of requesters; fixed at 8, matching the 3-bit mux select
//  SEL_W         3     width of mux_select_o, log2(NUM_REQ)
//  HOLD_TIMEOUT  1024  max cycles one requester may own the mux before forced release; must be >=2
//  TO_W          10    width of the watchdog counter; must hold HOLD_TIMEOUT-1
// PORTS
//  clk             in   1      system clock
//  rst             in   1      synchronous reset, active low
//  enable_i        in   1      1 = arbitration allowed; 0 = no new grants
//  req_i           in   8      per-requester level request; held until done or abandoned
//  done_i          in   8      per-requester 1-cycle pulse: all fifo and queue writes issued
//  spi_idle_i      in   1      top level finished the queued SPI write
//  grant_o         out  8      one-hot grant; the owner may write the fifos only while its bit is set
//  mux_select_o    out  SEL_W  index of the current owner, to spi_mux mux_select_i
//  mux_enable_o    out  1      to spi_mux enable_i
//  busy_o          out  1      1 in any state except IDLE
//  timeout_o       out  1      1-cycle pulse when the watchdog forces a release
//  timeout_id_o    out  SEL_W  index of the owner that timed out; held until the next timeout
// BEHAVIOUR
//  Reset (rst=0 at a clk edge):
//   - state=IDLE, grant_o=0, mux_select_o=0, mux_enable_o=0, busy_o=0, timeout_o=0, timeout_id_o=0
//   - rr_last=7, so requester 0 has first priority; watchdog counter=0
//   - Reset mid-transaction aborts it immediately. No done or timeout pulse is generated.
//  States and transitions:
//   - IDLE: outputs are 0.
//     If enable_i=1 and req_i!=0, pick the first set bit searching rr_last+1, rr_last+2, ... mod 8 -> GRANT.
//     Latency: req sampled at edge N; grant_o, mux_select_o and mux_enable_o are valid after edge N+1.
//   - GRANT: grant_o[sel]=1, mux_enable_o=1, watchdog increments each cycle.
//     - done_i[sel]=1 -> DRAIN.
//     - Else if req_i[sel]=0 (abandoned) -> RELEASE.
//     - Else if watchdog==HOLD_TIMEOUT-1 -> timeout_o=1, timeout_id_o=sel -> RELEASE.
//     - Priority when events coincide: done > abandon > timeout.
//   - DRAIN: grant_o=0; mux_enable_o=1 and mux_select_o held so the spi_mux flags stay routed.
//     The watchdog keeps counting.
//     - spi_idle_i=1 -> RELEASE.
//     - Watchdog expiry -> timeout pulse, then RELEASE.
//   - RELEASE: one dead cycle with grant_o=0, mux_enable_o=0, mux_select_o held. rr_last=sel, watchdog=0 -> IDLE.
//  Minimum gap between two grants is 2 cycles (RELEASE, then IDLE).
//  A requester can never regain ownership without passing through IDLE.
//  enable_i=0 while not IDLE: the current owner completes normally; no new grant is issued.
//  done_i bits of non-owners are ignored. req_i changes of non-owners have no effect until IDLE.
//  grant_o is always one-hot or zero. mux_select_o changes only on the IDLE->GRANT edge.
//  Registered outputs only; no combinational path from input to output.
// TESTING
//  1. Reset, then req_i=8'h01 -> grant_o=01 and mux_select_o=0 two edges later; done_i[0] pulse then spi_idle_i=1 -> IDLE 2 cycles later.
//  2. req_i=8'hFF held, each owner completes -> grant order 0,1,2,...,7,0; never two grant bits set.
//  3. req_i=8'h24 with rr_last=2 -> grant 5 first, then 2.
//  4. Owner 3 holds req with no done, HOLD_TIMEOUT=16 -> timeout_o pulse 16 cycles after grant, timeout_id_o=3, grant_o=0 next cycle.
//  5. done_i[sel] and req_i[sel] drop in the same cycle -> DRAIN taken, not RELEASE. done_i on a non-owner -> ignored.
//  6. rst=0 during DRAIN -> all outputs 0 next edge; enable_i=0 with req pending -> no grant until enable_i=1.

Source files
------------

// File: rtl/spi_arbiter.sv
// Round-robin arbiter handing exclusive ownership of the SPI data/queue fifos
// (via spi_mux) to one of eight requesters, with a watchdog for stuck owners.
module spi_arbiter #(
  parameter int NUM_REQ      = 8,
  parameter int SEL_W        = 3,
  parameter int HOLD_TIMEOUT = 1024,
  parameter int TO_W         = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] done_i,
  input  logic               spi_idle_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [SEL_W-1:0]   mux_select_o,
  output logic               mux_enable_o,
  output logic               busy_o,
  output logic               timeout_o,
  output logic [SEL_W-1:0]   timeout_id_o
);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN, RELEASE} state_t;

  state_t             state, state_next;
  logic [SEL_W-1:0]   sel, sel_next;
  logic [SEL_W-1:0]   rr_last, rr_last_next;
  logic [SEL_W-1:0]   timeout_id, timeout_id_next;
  logic [TO_W-1:0]    wd, wd_next;
  logic               timeout, timeout_next;
  logic [NUM_REQ-1:0] req_q;
  logic               en_q;
  logic               found;
  logic [SEL_W-1:0]   pick;
  logic [SEL_W-1:0]   idx;
  logic               wd_max;

  // Arbitration looks at the request/enable sampled one edge earlier.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      sel        <= '0;
      rr_last    <= SEL_W'(NUM_REQ - 1);
      timeout_id <= '0;
      wd         <= '0;
      timeout    <= 1'b0;
      req_q      <= '0;
      en_q       <= 1'b0;
    end else begin
      state      <= state_next;
      sel        <= sel_next;
      rr_last    <= rr_last_next;
      timeout_id <= timeout_id_next;
      wd         <= wd_next;
      timeout    <= timeout_next;
      req_q      <= req_i;
      en_q       <= enable_i;
    end
  end

  // First requester after the last owner, wrapping; i=NUM_REQ revisits rr_last itself.
  always_comb begin
    found = 1'b0;
    pick  = rr_last;
    idx   = rr_last;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = rr_last + SEL_W'(i);
      if (!found && req_q[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign wd_max = (wd == TO_W'(HOLD_TIMEOUT - 1));

  always_comb begin
    state_next      = state;
    sel_next        = sel;
    rr_last_next    = rr_last;
    timeout_id_next = timeout_id;
    wd_next         = wd;
    timeout_next    = 1'b0;
    case (state)
      IDLE: begin
        if (en_q && found) begin
          sel_next   = pick;
          wd_next    = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        // Saturate so a late done cannot wrap the counter while draining.
        if (!wd_max) wd_next = wd + TO_W'(1);
        if (done_i[sel]) begin
          state_next = DRAIN;
        end else if (!req_i[sel]) begin
          state_next = RELEASE;
        end else if (wd_max) begin
          timeout_next    = 1'b1;
          timeout_id_next = sel;
          state_next      = RELEASE;
        end
      end
      DRAIN: begin
        if (!wd_max) wd_next = wd + TO_W'(1);
        if (spi_idle_i) begin
          state_next = RELEASE;
        end else if (wd_max) begin
          timeout_next    = 1'b1;
          timeout_id_next = sel;
          state_next      = RELEASE;
        end
      end
      RELEASE: begin
        rr_last_next = sel;
        wd_next      = '0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign grant_o      = (state == GRANT) ? (NUM_REQ'(1) << sel) : '0;
  assign mux_select_o = sel;
  assign mux_enable_o = (state == GRANT) || (state == DRAIN);
  assign busy_o       = (state != IDLE);
  assign timeout_o    = timeout;
  assign timeout_id_o = timeout_id;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: stimulus pushes expected grants/timeouts,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_spi_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable_i = 1'b0;
  logic       spi_idle_i = 1'b0;
  logic [7:0] req_i = '0;
  logic [7:0] done_i = '0;
  logic [7:0] grant_o;
  logic [2:0] mux_select_o;
  logic       mux_enable_o;
  logic       busy_o;
  logic       timeout_o;
  logic [2:0] timeout_id_o;

  always #5 clk = ~clk;

  spi_arbiter #(.NUM_REQ(8), .SEL_W(3), .HOLD_TIMEOUT(16), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .req_i(req_i), .done_i(done_i),
    .spi_idle_i(spi_idle_i), .grant_o(grant_o), .mux_select_o(mux_select_o),
    .mux_enable_o(mux_enable_o), .busy_o(busy_o), .timeout_o(timeout_o),
    .timeout_id_o(timeout_id_o)
  );

  int total = 0;
  int bad = 0;
  logic [10:0] exp_grant_q[$];   // {sel, grant vector}
  logic [2:0]  exp_to_q[$];
  logic [10:0] eg;
  logic [2:0]  et;
  logic [7:0]  prev_grant = '0;
  logic [7:0]  g;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_grant(input int s);
    logic [7:0] v;
    v = 8'(1 << s);
    exp_grant_q.push_back({3'(s), v});
  endtask

  task automatic wait_grant(output logic [7:0] gv);
    int n = 0;
    while (grant_o == 0 && n < 20) begin
      tick();
      n++;
    end
    if (grant_o == 0) begin
      total++;
      bad++;
      $display("FAIL wait_grant: got no grant within 20 cycles expected a grant");
    end
    gv = grant_o;
  endtask

  // Owner finishes its writes, then the SPI processor reports idle.
  task automatic serve(input logic [7:0] gv);
    done_i = gv;
    tick();
    done_i = '0;
    check("drain_grant", grant_o, 0);
    check("drain_en", mux_enable_o, 1);
    spi_idle_i = 1'b1;
    tick();
    spi_idle_i = 1'b0;
    check("release_en", mux_enable_o, 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("onehot", int'($onehot0(grant_o)), 1);
      if (grant_o != 0 && prev_grant == 0) begin
        $display("grant vec=%02h sel=%0d", grant_o, mux_select_o);
        if (exp_grant_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_grant: got %02h expected none", grant_o);
        end else begin
          eg = exp_grant_q.pop_front();
          check("grant_vec", grant_o, eg[7:0]);
          check("grant_sel", mux_select_o, eg[10:8]);
        end
      end
      if (timeout_o) begin
        $display("timeout id=%0d", timeout_id_o);
        if (exp_to_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_timeout: got id %0d expected none", timeout_id_o);
        end else begin
          et = exp_to_q.pop_front();
          check("timeout_id", timeout_id_o, et);
        end
      end
    end
    prev_grant = grant_o;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    // 1: reset state, latency, simple done/idle cycle
    tick(); tick();
    check("rst_grant", grant_o, 0);
    check("rst_sel", mux_select_o, 0);
    check("rst_en", mux_enable_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_to", timeout_o, 0);
    check("rst_toid", timeout_id_o, 0);
    rst = 1'b1;
    enable_i = 1'b1;
    req_i = 8'h01;
    push_grant(0);
    tick();
    check("lat_early", grant_o, 0);
    tick();
    check("t1_grant", grant_o, 8'h01);
    check("t1_sel", mux_select_o, 0);
    check("t1_en", mux_enable_o, 1);
    check("t1_busy", busy_o, 1);
    done_i = 8'h01;
    req_i = 8'h00;
    tick();
    done_i = '0;
    check("t1_drain_grant", grant_o, 0);
    check("t1_drain_en", mux_enable_o, 1);
    spi_idle_i = 1'b1;
    tick();
    spi_idle_i = 1'b0;
    check("t1_rel_en", mux_enable_o, 0);
    check("t1_rel_busy", busy_o, 1);
    check("t1_rel_sel", mux_select_o, 0);
    tick();
    check("t1_idle_busy", busy_o, 0);

    // 2: all requesting, rotation continues after owner 0
    req_i = 8'hFF;
    for (int i = 1; i <= 9; i++) push_grant(i % 8);
    for (int i = 0; i < 9; i++) begin
      wait_grant(g);
      serve(g);
    end
    req_i = 8'h00;
    tick();

    // 3: rr_last=2 with requesters 2 and 5 -> 5 then 2
    req_i = 8'h04;
    push_grant(2);
    wait_grant(g);
    serve(g);
    req_i = 8'h00;
    tick();
    req_i = 8'h24;
    push_grant(5);
    push_grant(2);
    wait_grant(g);
    check("t3_first", g, 8'h20);
    serve(g);
    req_i = 8'h04;
    wait_grant(g);
    check("t3_second", g, 8'h04);
    serve(g);
    req_i = 8'h00;
    tick();

    // 4: owner 3 never finishes -> watchdog release after 16 cycles
    req_i = 8'h08;
    push_grant(3);
    exp_to_q.push_back(3'd3);
    wait_grant(g);
    repeat (15) tick();
    check("t4_still_grant", grant_o, 8'h08);
    check("t4_no_to_yet", timeout_o, 0);
    tick();
    check("t4_to", timeout_o, 1);
    check("t4_grant_off", grant_o, 0);
    check("t4_toid", timeout_id_o, 3);
    req_i = 8'h00;
    tick();
    check("t4_to_pulse", timeout_o, 0);
    check("t4_toid_held", timeout_id_o, 3);
    check("t4_idle", busy_o, 0);

    // 5: non-owner done ignored; done with req drop -> DRAIN
    req_i = 8'h10;
    push_grant(4);
    wait_grant(g);
    done_i = 8'h01;
    tick();
    done_i = '0;
    check("t5_nonowner_done", grant_o, 8'h10);
    done_i = 8'h10;
    req_i = 8'h00;
    tick();
    done_i = '0;
    check("t5_drain_grant", grant_o, 0);
    check("t5_drain_en", mux_enable_o, 1);
    check("t5_drain_sel", mux_select_o, 4);

    // 6: reset while draining, then enable gating
    rst = 1'b0;
    tick();
    check("t6_grant", grant_o, 0);
    check("t6_sel", mux_select_o, 0);
    check("t6_en", mux_enable_o, 0);
    check("t6_busy", busy_o, 0);
    check("t6_toid", timeout_id_o, 0);
    rst = 1'b1;
    enable_i = 1'b0;
    req_i = 8'h06;
    repeat (4) tick();
    check("t6_disabled_grant", grant_o, 0);
    check("t6_disabled_busy", busy_o, 0);
    push_grant(1);
    enable_i = 1'b1;
    tick();
    check("t6_en_lat", grant_o, 0);
    tick();
    check("t6_en_grant", grant_o, 8'h02);
    serve(grant_o);
    req_i = 8'h00;
    tick();

    // 7: owner abandons its request -> straight to RELEASE
    req_i = 8'h08;
    push_grant(3);
    wait_grant(g);
    req_i = 8'h00;
    tick();
    check("t7_rel_en", mux_enable_o, 0);
    check("t7_rel_busy", busy_o, 1);
    tick();
    check("t7_idle", busy_o, 0);

    repeat (3) tick();
    check("grant_q_empty", exp_grant_q.size(), 0);
    check("to_q_empty", exp_to_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
